mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Target-side endpoint of the register/address/data request interface.
//   Accepts one request at a time (read or write, 2-bit address, 2-bit data)
//     into a small register-file memory.
//   Returns a response after a programmable number of wait states.
//   Sits opposite the request-issuing register/address/data pipeline; one outstanding transaction.
// PARAMETERS
//   ADDR_W       2   request address width
//   DATA_W       2   data width (write data, read data, memory entries)
//   DEPTH        4   implemented entries, 1..2**ADDR_W; addresses >= DEPTH are errors
//   WAIT_STATES  0   extra cycles between accept and response, 0..15
//   CNT_W        8   width of completed-transaction counter
// PORTS
//   clock      in   1        rising-edge clock
//   rst        in   1        asynchronous, active-low reset
//   req_valid  in   1        request present
//   req_ready  out  1        responder can accept (high only in IDLE)
//   req_wr     in   1        1 = write, 0 = read
//   req_addr   in   ADDR_W   target entry
//   req_wdata  in   DATA_W   write data
//   rsp_valid  out  1        response present
//   rsp_ready  in   1        requester takes response
//   rsp_rdata  out  DATA_W   read data (0 for writes and errors)
//   rsp_err    out  1        address out of range
//   txn_count  out  CNT_W    completed responses, wraps
// BEHAVIOUR
//   Reset (rst=0, async): state IDLE, all DEPTH entries 0, req_ready=1, rsp_valid=0,
//     rsp_rdata=0, rsp_err=0, txn_count=0, wait counter 0. Any in-flight request is dropped.
//   States: IDLE, WAIT, RESP (registered); req_ready=(state==IDLE), rsp_valid=(state==RESP).
//   IDLE: on req_valid&req_ready at edge k, capture wr/addr/wdata.
//     WAIT_STATES=0 -> RESP; else -> WAIT, counter=WAIT_STATES-1.
//   WAIT: counter decrements each edge; at counter==0 -> RESP. req_valid ignored.
//   Entering RESP (single edge): write commits mem[addr]=wdata; read samples rsp_rdata=mem[addr];
//     if addr>=DEPTH: no write, rsp_rdata=0, rsp_err=1; writes return rsp_rdata=0.
//   Latency: accept edge k -> rsp_valid high in cycle k+1+WAIT_STATES.
//   RESP: rsp_valid/rsp_rdata/rsp_err held stable until rsp_ready=1;
//     on rsp_valid&rsp_ready edge -> IDLE, txn_count+1 (wraps 2**CNT_W-1 -> 0),
//     rsp_rdata/rsp_err cleared to 0.
//   No accept in same cycle as response handshake: back-to-back throughput is one
//     transaction per 2+WAIT_STATES cycles minimum.
//   Read-after-write to same address always returns new data (single outstanding txn).
//   req_* inputs only sampled at accept edge; changes afterwards have no effect.
//   rsp_ready high while not RESP: ignored.
// TESTING
//   1 Reset: hold rst=0 2 cycles -> req_ready=1, rsp_valid=0, txn_count=0; read each addr -> 0.
//   2 WAIT_STATES=0: write addr=2 data=3, then read addr=2
//     -> each rsp_valid in cycle after accept; read rsp_rdata=3, rsp_err=0, txn_count=2.
//   3 WAIT_STATES=3: read accepted edge k -> rsp_valid first high cycle k+4;
//     req_ready=0 cycles k+1..k+4.
//   4 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_rdata/rsp_err stable,
//     req_valid=1 not accepted; rsp_ready=1 -> IDLE next cycle.
//   5 DEPTH=3: write addr=3 data=1 -> rsp_err=1, rsp_rdata=0; entries 0..2 unchanged.
//   6 Reset mid-WAIT on pending write addr=1 data=2 -> no response; read addr=1 returns 0.
//     Counter wrap: CNT_W=2, 4 txns -> txn_count=0.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between a register/address/data requester and a memory responder.
// The master drives requests and accepts responses; the slave does the opposite.
interface mem_responder_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one read/write request, waits a fixed
// number of cycles, then presents a held response and counts completed transactions.
module mem_responder #(
    parameter int ADDR_W      = 2,
    parameter int DATA_W      = 2,
    parameter int DEPTH       = 4,
    parameter int WAIT_STATES = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             rst,
    mem_responder_if.slave   bus,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit       NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        wait_cnt_r;
    logic [3:0]        wait_cnt_s;
    logic              wr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;
    logic              err_r;
    logic              req_ready_r;
    logic              rsp_valid_r;
    logic [CNT_W-1:0]  txn_count_r;

    logic              accept_s;
    logic              done_s;
    logic              enter_resp_s;
    logic              sel_wr_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              in_range_s;
    logic [DATA_W-1:0] rd_data_s;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(DEPTH));
    endfunction

    assign accept_s = bus.req_valid & (state_r == ST_IDLE);
    assign done_s   = bus.rsp_ready & (state_r == ST_RESP);

    // State register and wait counter
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (NO_WAIT) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s    = ST_WAIT;
                        wait_cnt_s = WAIT_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    wait_cnt_s = wait_cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                wait_cnt_s = 4'd0;
            end
        endcase
    end

    // Output/datapath decode: with no wait states the live request is used on the accept edge
    always_comb begin
        enter_resp_s = 1'b0;
        sel_wr_s     = wr_r;
        sel_addr_s   = addr_r;
        sel_wdata_s  = wdata_r;
        case (state_r)
            ST_IDLE: begin
                enter_resp_s = accept_s & NO_WAIT;
                sel_wr_s     = bus.req_wr;
                sel_addr_s   = bus.req_addr;
                sel_wdata_s  = bus.req_wdata;
            end
            ST_WAIT: begin
                enter_resp_s = (wait_cnt_r == 4'd0);
            end
            ST_RESP: begin
                enter_resp_s = 1'b0;
            end
            default: begin
                enter_resp_s = 1'b0;
            end
        endcase
        in_range_s = addr_ok(sel_addr_s);
        rd_data_s  = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_addr_s == ADDR_W'(i)) begin
                rd_data_s = mem_r[i];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Request capture on accept
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            wr_r    <= bus.req_wr;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
        end else begin
            wr_r    <= wr_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Register-file memory; out-of-range writes never match an entry
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enter_resp_s && sel_wr_s && (sel_addr_s == ADDR_W'(i))) begin
                    mem_r[i] <= sel_wdata_s;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    // Response payload, held through backpressure and cleared on handshake
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else if (enter_resp_s) begin
            rdata_r <= (sel_wr_s || !in_range_s) ? {DATA_W{1'b0}} : rd_data_s;
            err_r   <= !in_range_s;
        end else if (done_s) begin
            rdata_r <= {DATA_W{1'b0}};
            err_r   <= 1'b0;
        end else begin
            rdata_r <= rdata_r;
            err_r   <= err_r;
        end
    end

    // Handshake flags registered from the next state so they track state_r exactly
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            req_ready_r <= (state_s == ST_IDLE);
            rsp_valid_r <= (state_s == ST_RESP);
        end
    end

    // Completed-transaction counter, wraps naturally
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            txn_count_r <= {CNT_W{1'b0}};
        end else if (done_s) begin
            txn_count_r <= txn_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            txn_count_r <= txn_count_r;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rdata_r;
    assign bus.rsp_err   = err_r;
    assign txn_count     = txn_count_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder: one instance with no wait states and
// full depth, one with three wait states, three entries and a 2-bit transaction counter.
module tb_mem_responder;

    logic       clock;
    logic       rst [2];
    logic       req_v [2];
    logic       req_wr [2];
    logic [1:0] req_addr [2];
    logic [1:0] req_wdata [2];
    logic       rsp_r [2];
    logic [7:0] txn0;
    logic [1:0] txn1;

    int total;
    int bad;
    int cnt_m [2];

    mem_responder_if #(.ADDR_W(2), .DATA_W(2)) bus0 ();
    mem_responder_if #(.ADDR_W(2), .DATA_W(2)) bus1 ();

    assign bus0.req_valid = req_v[0];
    assign bus0.req_wr    = req_wr[0];
    assign bus0.req_addr  = req_addr[0];
    assign bus0.req_wdata = req_wdata[0];
    assign bus0.rsp_ready = rsp_r[0];
    assign bus1.req_valid = req_v[1];
    assign bus1.req_wr    = req_wr[1];
    assign bus1.req_addr  = req_addr[1];
    assign bus1.req_wdata = req_wdata[1];
    assign bus1.rsp_ready = rsp_r[1];

    mem_responder #(.ADDR_W(2), .DATA_W(2), .DEPTH(4), .WAIT_STATES(0), .CNT_W(8)) dut0 (
        .clock(clock), .rst(rst[0]), .bus(bus0), .txn_count(txn0)
    );

    mem_responder #(.ADDR_W(2), .DATA_W(2), .DEPTH(3), .WAIT_STATES(3), .CNT_W(2)) dut1 (
        .clock(clock), .rst(rst[1]), .bus(bus1), .txn_count(txn1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int d;
        int wr;
        int addr;
        int wdata;
        int hold;
        int rdata;
        int err;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(int d, int wr, int addr, int wdata, int hold, int rdata, int err);
        vec_t v;
        v.d = d; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.hold = hold; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    function automatic int get_rdy(int d);
        return (d == 0) ? int'(bus0.req_ready) : int'(bus1.req_ready);
    endfunction
    function automatic int get_val(int d);
        return (d == 0) ? int'(bus0.rsp_valid) : int'(bus1.rsp_valid);
    endfunction
    function automatic int get_rdata(int d);
        return (d == 0) ? int'(bus0.rsp_rdata) : int'(bus1.rsp_rdata);
    endfunction
    function automatic int get_err(int d);
        return (d == 0) ? int'(bus0.rsp_err) : int'(bus1.rsp_err);
    endfunction
    function automatic int get_cnt(int d);
        return (d == 0) ? int'(txn0) : int'(txn1);
    endfunction
    function automatic int ws(int d);
        return (d == 0) ? 0 : 3;
    endfunction
    function automatic int cmask(int d);
        return (d == 0) ? 255 : 3;
    endfunction

    task automatic chk(input string name, input int d, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, got, exp, $time);
        end
    endtask

    // one full transaction; entered and left #1 after a rising edge with the DUT idle
    task automatic run_txn(input vec_t v);
        int d;
        int lat;
        d = v.d;
        chk("ready_idle", d, get_rdy(d), 1);
        req_v[d]     = 1'b1;
        req_wr[d]    = 1'(v.wr);
        req_addr[d]  = 2'(v.addr);
        req_wdata[d] = 2'(v.wdata);
        rsp_r[d]     = 1'b0;
        @(posedge clock); #1;
        req_wr[d]    = ~1'(v.wr);
        req_addr[d]  = 2'(v.addr) ^ 2'd1;
        req_wdata[d] = ~2'(v.wdata);
        lat = 1;
        while (get_val(d) == 0 && lat < 40) begin
            chk("ready_busy", d, get_rdy(d), 0);
            @(posedge clock); #1;
            lat++;
        end
        chk("latency", d, lat, 1 + ws(d));
        chk("ready_resp", d, get_rdy(d), 0);
        chk("rdata", d, get_rdata(d), v.rdata);
        chk("err", d, get_err(d), v.err);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clock); #1;
            chk("hold_valid", d, get_val(d), 1);
            chk("hold_ready", d, get_rdy(d), 0);
            chk("hold_rdata", d, get_rdata(d), v.rdata);
            chk("hold_err", d, get_err(d), v.err);
        end
        rsp_r[d] = 1'b1;
        req_v[d] = 1'b0;
        @(posedge clock); #1;
        rsp_r[d] = 1'b0;
        cnt_m[d] = (cnt_m[d] + 1) & cmask(d);
        chk("post_valid", d, get_val(d), 0);
        chk("post_ready", d, get_rdy(d), 1);
        chk("post_rdata", d, get_rdata(d), 0);
        chk("post_err", d, get_err(d), 0);
        chk("txn_count", d, get_cnt(d), cnt_m[d]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; req_v[i] = 1'b0; req_wr[i] = 1'b0;
            req_addr[i] = 2'd0; req_wdata[i] = 2'd0; rsp_r[i] = 1'b0; cnt_m[i] = 0;
        end

        // dut, wr, addr, wdata, hold, expected rdata, expected err
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2, 0, 5, 3, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 2, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3, 0, 0, 0, 1));
        vecs.push_back(mk(1, 1, 0, 2, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 3, 5, 0, 0));
        vecs.push_back(mk(1, 1, 3, 1, 3, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 2, 0, 0, 3, 0));
        vecs.push_back(mk(1, 0, 3, 0, 2, 0, 1));
        vecs.push_back(mk(0, 0, 2, 0, 0, 3, 0));

        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, get_rdy(d), 1);
            chk("rst_valid", d, get_val(d), 0);
            chk("rst_count", d, get_cnt(d), 0);
            chk("rst_rdata", d, get_rdata(d), 0);
            chk("rst_err", d, get_err(d), 0);
        end
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            run_txn(vecs[i]);
        end

        // reset dut1 while a write to entry 1 sits in WAIT
        req_v[1] = 1'b1; req_wr[1] = 1'b1; req_addr[1] = 2'd1; req_wdata[1] = 2'd2;
        @(posedge clock); #1;
        req_v[1] = 1'b0;
        @(posedge clock); #1;
        chk("midwait_busy", 1, get_rdy(1), 0);
        rst[1] = 1'b0;
        #1;
        chk("async_ready", 1, get_rdy(1), 1);
        chk("async_valid", 1, get_val(1), 0);
        chk("async_count", 1, get_cnt(1), 0);
        @(posedge clock); #1;
        rst[1] = 1'b1;
        cnt_m[1] = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            chk("dropped_valid", 1, get_val(1), 0);
        end
        run_txn(mk(1, 0, 1, 0, 0, 0, 0));
        run_txn(mk(1, 0, 0, 0, 0, 0, 0));
        run_txn(mk(0, 0, 1, 0, 0, 2, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
